// File: rtl/bram_pattern_checker.sv
// BRAM write/read-back self-test: fills port A with a pattern, reads it back on port B, reports errors.
// Optional LFSR pattern generator compiled in with `BRAM_CHK_LFSR_EN` (otherwise incrementing only).
module bram_pattern_checker #(
    parameter int unsigned       DATA_W    = 16,
    parameter int unsigned       ADDR_W    = 11,
    parameter int unsigned       DEPTH     = 2048,
    parameter int unsigned       PERIOD    = 50_000_000,
    parameter int unsigned       RD_LAT    = 1,
    parameter int unsigned       ERR_W     = 16,
    parameter logic [DATA_W-1:0] LFSR_TAPS = DATA_W'(16'hB400)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              auto_en,
    input  logic              start,
    input  logic              mode,
    input  logic [DATA_W-1:0] seed,
    output logic              bram_wea,
    output logic [ADDR_W-1:0] bram_addra,
    output logic [DATA_W-1:0] bram_dina,
    output logic              bram_enb,
    output logic [ADDR_W-1:0] bram_addrb,
    input  logic [DATA_W-1:0] bram_doutb,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic              overrun,
    output logic [2:0]        dbg_state
);
    localparam int unsigned PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_FLUSH, S_REPORT} state_t;

    state_t              r_state;
    logic [PW-1:0]       r_period;
    logic [DATA_W-1:0]   r_seed;
    logic [DATA_W-1:0]   r_gen;
    logic                r_wea;
    logic [ADDR_W-1:0]   r_addra;
    logic                r_enb;
    logic [ADDR_W-1:0]   r_addrb;
    logic [1:0]          r_fcnt;
    logic                r_busy;
    logic                r_done;
    logic                r_pass;
    logic [ERR_W-1:0]    r_err;
    logic [ADDR_W-1:0]   r_first;
    logic                r_first_flag;
    logic                r_overrun;
    logic [RD_LAT-1:0]   r_pv;
    logic [DATA_W-1:0]   r_pe [RD_LAT];
    logic [ADDR_W-1:0]   r_pa [RD_LAT];

    logic                w_auto;
    logic                w_trig;
    logic                w_mis;
    logic [ERR_W-1:0]    w_err_nxt;
    logic [DATA_W-1:0]   w_first_acc;
    logic [DATA_W-1:0]   w_first_lat;
    logic [DATA_W-1:0]   w_next_gen;

    assign w_auto    = auto_en && (r_period == PW'(PERIOD - 1));
    assign w_trig    = start || w_auto;
    assign w_mis     = r_pv[RD_LAT-1] && (bram_doutb != r_pe[RD_LAT-1]);
    assign w_err_nxt = (w_mis && (r_err != '1)) ? r_err + 1'b1 : r_err;

`ifdef BRAM_CHK_LFSR_EN
    logic r_mode;
    // An all-zero LFSR state would lock up, so a zero seed starts at 1.
    assign w_first_acc = (mode && (seed == '0)) ? DATA_W'(1) : seed;
    assign w_first_lat = (r_mode && (r_seed == '0)) ? DATA_W'(1) : r_seed;
    assign w_next_gen  = r_mode ? {r_gen[DATA_W-2:0], ^(r_gen & LFSR_TAPS)} : r_gen + 1'b1;
`else
    logic [DATA_W:0] w_unused_cfg;
    assign w_unused_cfg = {mode, LFSR_TAPS};
    assign w_first_acc  = seed;
    assign w_first_lat  = r_seed;
    assign w_next_gen   = r_gen + 1'b1;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_period     <= '0;
            r_seed       <= '0;
`ifdef BRAM_CHK_LFSR_EN
            r_mode       <= 1'b0;
`endif
            r_gen        <= '0;
            r_wea        <= 1'b0;
            r_addra      <= '0;
            r_enb        <= 1'b0;
            r_addrb      <= '0;
            r_fcnt       <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_err        <= '0;
            r_first      <= '0;
            r_first_flag <= 1'b0;
            r_overrun    <= 1'b0;
            r_pv         <= '0;
            for (int i = 0; i < int'(RD_LAT); i++) begin
                r_pe[i] <= '0;
                r_pa[i] <= '0;
            end
        end else begin
            r_period <= (r_period == PW'(PERIOD - 1)) ? '0 : r_period + 1'b1;

            // Expected word and address travel with the read request for RD_LAT cycles.
            r_pv[0] <= r_enb;
            r_pe[0] <= r_gen;
            r_pa[0] <= r_addrb;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pe[i] <= r_pe[i-1];
                r_pa[i] <= r_pa[i-1];
            end

            r_err <= w_err_nxt;
            if (w_mis && !r_first_flag) begin
                r_first      <= r_pa[RD_LAT-1];
                r_first_flag <= 1'b1;
            end

            if (w_trig && (r_state != S_IDLE))
                r_overrun <= 1'b1;

            r_done <= 1'b0;
            r_wea  <= 1'b0;
            r_enb  <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_trig) begin
                        r_seed       <= seed;
`ifdef BRAM_CHK_LFSR_EN
                        r_mode       <= mode;
`endif
                        r_err        <= '0;
                        r_first      <= '0;
                        r_first_flag <= 1'b0;
                        r_pass       <= 1'b0;
                        r_busy       <= 1'b1;
                        r_wea        <= 1'b1;
                        r_addra      <= '0;
                        r_gen        <= w_first_acc;
                        r_state      <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (r_addra == ADDR_W'(DEPTH - 1)) begin
                        r_enb   <= 1'b1;
                        r_addrb <= '0;
                        r_gen   <= w_first_lat;
                        r_state <= S_READ;
                    end else begin
                        r_wea   <= 1'b1;
                        r_addra <= r_addra + 1'b1;
                        r_gen   <= w_next_gen;
                    end
                end
                S_READ: begin
                    if (r_addrb == ADDR_W'(DEPTH - 1)) begin
                        r_fcnt  <= '0;
                        r_state <= S_FLUSH;
                    end else begin
                        r_enb   <= 1'b1;
                        r_addrb <= r_addrb + 1'b1;
                        r_gen   <= w_next_gen;
                    end
                end
                S_FLUSH: begin
                    if (r_fcnt == 2'(RD_LAT - 1)) begin
                        // The final compare lands on this same edge, so judge on the next count.
                        r_done  <= 1'b1;
                        r_pass  <= (w_err_nxt == '0);
                        r_state <= S_REPORT;
                    end else begin
                        r_fcnt <= r_fcnt + 1'b1;
                    end
                end
                S_REPORT: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bram_wea       = r_wea;
    assign bram_addra     = r_addra;
    assign bram_dina      = r_gen;
    assign bram_enb       = r_enb;
    assign bram_addrb     = r_addrb;
    assign busy           = r_busy;
    assign done           = r_done;
    assign pass           = r_pass;
    assign err_count      = r_err;
    assign first_err_addr = r_first;
    assign overrun        = r_overrun;
    assign dbg_state      = r_state;

endmodule

// File: tb/tb_bram_pattern_checker.sv
// Bench for bram_pattern_checker: BRAM model with fault injection, run-position reference model,
// per-cycle compare process and directed/random runs.
module tb_bram_pattern_checker;
    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 11;
    localparam int DEPTH   = 16;
    localparam int PERIOD  = 20;
    localparam int RD_LAT  = 1;
    localparam int ERR_W   = 2;
    localparam int RUN_LEN = 2 * DEPTH + RD_LAT + 1;
    localparam int ERR_MAX = (1 << ERR_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              auto_en = 1'b0;
    logic              start = 1'b0;
    logic              mode = 1'b0;
    logic [DATA_W-1:0] seed = '0;
    logic              bram_wea;
    logic [ADDR_W-1:0] bram_addra;
    logic [DATA_W-1:0] bram_dina;
    logic              bram_enb;
    logic [ADDR_W-1:0] bram_addrb;
    logic [DATA_W-1:0] bram_doutb;
    logic              busy;
    logic              done;
    logic              pass;
    logic [ERR_W-1:0]  err_count;
    logic [ADDR_W-1:0] first_err_addr;
    logic              overrun;
    logic [2:0]        dbg_state;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    bram_pattern_checker #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .PERIOD(PERIOD),
        .RD_LAT(RD_LAT), .ERR_W(ERR_W), .LFSR_TAPS(16'hB400)
    ) dut (
        .clk(clk), .rst(rst_n), .auto_en(auto_en), .start(start), .mode(mode), .seed(seed),
        .bram_wea(bram_wea), .bram_addra(bram_addra), .bram_dina(bram_dina),
        .bram_enb(bram_enb), .bram_addrb(bram_addrb), .bram_doutb(bram_doutb),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_err_addr(first_err_addr), .overrun(overrun), .dbg_state(dbg_state)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Block RAM model; corrupt[] flips read data at chosen addresses.
    logic [DATA_W-1:0] mem [1 << ADDR_W];
    logic [DATA_W-1:0] rd_pipe [RD_LAT];
    logic [15:0]       corrupt = '0;

    always @(posedge clk) begin
        if (bram_wea) mem[bram_addra] <= bram_dina;
        if (bram_enb)
            rd_pipe[0] <= mem[bram_addrb] ^
                ((int'(bram_addrb) < DEPTH && corrupt[bram_addrb[3:0]]) ? 16'h5A5A : 16'h0000);
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bram_doutb = rd_pipe[RD_LAT-1];

    // Reference model: position in the run (0 = idle, 1 = first write cycle, RUN_LEN = report).
    int                m_cnt = 0;
    int                m_p = 0;
    int                m_hold = 0;
    logic              m_over = 1'b0;
    logic [15:0]       m_corrupt = '0;
    logic [DATA_W-1:0] m_pat [DEPTH];

    function automatic logic [DATA_W-1:0] pat_word(input logic md, input logic [DATA_W-1:0] sd,
                                                   input int k);
        logic [DATA_W-1:0] w;
`ifdef BRAM_CHK_LFSR_EN
        if (md) begin
            w = (sd == 0) ? 16'h0001 : sd;
            repeat (k) w = {w[14:0], ^(w & 16'hB400)};
            return w;
        end
`endif
        w = sd + DATA_W'(k);
        return w;
    endfunction

    // The compare for address a becomes visible DEPTH+2+a+RD_LAT cycles into the run.
    function automatic int exp_err(input int h);
        int n = 0;
        for (int a = 0; a < DEPTH; a++)
            if (m_corrupt[a] && (DEPTH + 2 + a + RD_LAT <= h)) n++;
        return (n > ERR_MAX) ? ERR_MAX : n;
    endfunction

    function automatic int exp_first(input int h);
        for (int a = 0; a < DEPTH; a++)
            if (m_corrupt[a] && (DEPTH + 2 + a + RD_LAT <= h)) return a;
        return 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt = 0; m_p = 0; m_hold = 0; m_over = 1'b0; m_corrupt = '0;
        end else begin
            logic trig;
            trig = start || (auto_en && m_cnt == PERIOD - 1);
            if (m_p == 0) begin
                if (trig) begin
                    m_p = 1; m_hold = 1; m_corrupt = corrupt;
                    for (int k = 0; k < DEPTH; k++) m_pat[k] = pat_word(mode, seed, k);
                end
            end else begin
                if (trig) m_over = 1'b1;
                m_p = (m_p == RUN_LEN) ? 0 : m_p + 1;
                if (m_p != 0) m_hold = m_p;
            end
            m_cnt = (m_cnt + 1) % PERIOD;
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            logic ew, ee;
            ew = (m_p >= 1) && (m_p <= DEPTH);
            ee = (m_p >= DEPTH + 1) && (m_p <= 2 * DEPTH);
            chk("wea", bram_wea, ew);
            if (ew) begin
                chk("addra", bram_addra, m_p - 1);
                chk("dina", bram_dina, m_pat[m_p-1]);
            end
            chk("enb", bram_enb, ee);
            if (ee) chk("addrb", bram_addrb, m_p - DEPTH - 1);
            chk("busy", busy, m_p != 0);
            chk("done", done, m_p == RUN_LEN);
            chk("overrun", overrun, m_over);
            chk("err_count", err_count, exp_err(m_hold));
            chk("first_err_addr", first_err_addr, exp_first(m_hold));
            if (m_p == RUN_LEN) chk("pass", pass, m_corrupt == 0);
        end
    end

    // Starts a run from the current negedge and waits for done.
    task automatic do_run(input logic [15:0] sd, input logic md, output int lat,
                          output logic [15:0] d0, output logic [15:0] d1, output logic [15:0] dl,
                          output logic p, output logic [ERR_W-1:0] e, output logic [ADDR_W-1:0] fa);
        seed = sd; mode = md; start = 1'b1;
        @(negedge clk);
        start = 1'b0; lat = 1; d0 = 'x; d1 = 'x; dl = 'x;
        while (!done && lat < 400) begin
            if (bram_wea && bram_addra == 0) d0 = bram_dina;
            if (bram_wea && bram_addra == 1) d1 = bram_dina;
            if (bram_wea && bram_addra == DEPTH - 1) dl = bram_dina;
            @(negedge clk);
            lat++;
        end
        chk("run_done_seen", done, 1'b1);
        p = pass; e = err_count; fa = first_err_addr;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        n_bad++;
        $display("FAIL watchdog: time limit reached");
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        int lat, n;
        logic [15:0] d0, d1, dl;
        logic p;
        logic [ERR_W-1:0] e;
        logic [ADDR_W-1:0] fa;

        repeat (3) @(negedge clk);
        chk("rst_wea", bram_wea, 0);
        chk("rst_enb", bram_enb, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pass", pass, 0);
        chk("rst_dina", bram_dina, 0);
        #2 rst_n = 1'b1;
        repeat (100) @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_pass", pass, 0);
        chk("idle_err", err_count, 0);

        // Incrementing pass run.
        do_run(16'h00F0, 1'b0, lat, d0, d1, dl, p, e, fa);
        chk("inc_latency", lat, 34);
        chk("inc_word0", d0, 16'h00F0);
        chk("inc_word_last", dl, 16'h00FF);
        chk("inc_pass", p, 1);
        chk("inc_err", e, 0);

        // Fault injection at addresses 5 and 9.
        corrupt = 16'h0220;
        do_run(16'h1234, 1'b0, lat, d0, d1, dl, p, e, fa);
        chk("flt_err", e, 2);
        chk("flt_first", fa, 5);
        chk("flt_pass", p, 0);

        // Five faults saturate a 2-bit counter.
        corrupt = 16'h0F20;
        do_run(16'hFFF8, 1'b0, lat, d0, d1, dl, p, e, fa);
        chk("sat_err", e, ERR_MAX);
        chk("sat_first", fa, 5);
        chk("sat_wrap_word", dl, 16'h0007);

`ifdef BRAM_CHK_LFSR_EN
        corrupt = '0;
        do_run(16'h0000, 1'b1, lat, d0, d1, dl, p, e, fa);
        chk("lfsr_word0", d0, 16'h0001);
        chk("lfsr_word1", d1, 16'h0002);
        chk("lfsr_pass", p, 1);
`endif

        // Random runs, back to back or with short gaps.
        for (int r = 0; r < 8; r++) begin
            corrupt = 16'($urandom & $urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_run(16'($urandom), 1'($urandom_range(0, 1)), lat, d0, d1, dl, p, e, fa);
        end
        chk("rand_no_overrun", overrun, 0);

        // Trigger during REPORT is dropped and sets overrun.
        corrupt = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0; n = 0;
        while (!done && n < 100) begin @(negedge clk); n++; end
        chk("rep_done_seen", done, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("rep_overrun", overrun, 1);
        chk("rep_not_busy", busy, 0);

        // Mid-run reset at write word 7.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0; n = 0;
        while (!(bram_wea && bram_addra == 7) && n < 100) begin @(negedge clk); n++; end
        chk("mrr_at_word7", bram_addra, 7);
        #2 rst_n = 1'b0;
        #1;
        chk("mrr_wea", bram_wea, 0);
        chk("mrr_busy", busy, 0);
        chk("mrr_done", done, 0);
        chk("mrr_overrun", overrun, 0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        do_run(16'h0A00, 1'b0, lat, d0, d1, dl, p, e, fa);
        chk("mrr_pass", p, 1);
        chk("mrr_latency", lat, 34);

        // Start coinciding with auto-trigger gives one run and no overrun.
        auto_en = 1'b1; n = 0;
        while (m_cnt != PERIOD - 1 && n < 3 * PERIOD) begin @(negedge clk); n++; end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0; auto_en = 1'b0; n = 0;
        while (!done && n < 100) begin @(negedge clk); n++; end
        chk("sim_pass", pass, 1);
        @(negedge clk);
        chk("sim_overrun", overrun, 0);

        // Auto-trigger from reset: run at count 19, overrun at the next expiry.
        #2 rst_n = 1'b0;
        auto_en = 1'b1;
        @(negedge clk);
        #2 rst_n = 1'b1;
        n = 0;
        while (!busy && n < 100) begin @(negedge clk); n++; end
        chk("auto_start_cycle", n, 20);
        while (!overrun && n < 200) begin @(negedge clk); n++; end
        chk("auto_overrun_cycle", n, 40);
        auto_en = 1'b0; n = 0;
        while (busy && n < 100) begin @(negedge clk); n++; end
        chk("auto_idle", busy, 0);
        repeat (5) @(negedge clk);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
